// File: rtl/rgb2gray.sv
// rgb2gray: two-stage stallable RGB-to-grayscale converter.
// Stage 1 sums R+G+B and stage 2 divides the sum by 3. Pushes are counted
// per frame, and frame_done pulses once after the last pixel of each frame.
module rgb2gray #(
  parameter int DWIDTH_IN  = 24,
  parameter int DWIDTH_OUT = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  fifo_in_rd_en,
  input  logic [DWIDTH_IN-1:0]  fifo_in_dout,
  input  logic                  fifo_in_empty,
  output logic                  fifo_out_wr_en,
  output logic [DWIDTH_OUT-1:0] fifo_out_din,
  input  logic                  fifo_out_full,
  output logic                  frame_done
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [9:0]            sum_r;
  logic [9:0]            sum_next;
  logic                  v1;
  logic                  out_valid;
  logic                  adv;
  logic [19:0]           prod;
  logic [DWIDTH_OUT-1:0] div3;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;

  // Single pipeline enable: both stages move unless a valid pixel is blocked.
  assign adv            = ~out_valid | ~fifo_out_full;
  // Reset gates both handshakes so nothing is popped or pushed during reset.
  assign fifo_in_rd_en  = ~reset & ~fifo_in_empty & adv;
  assign fifo_out_wr_en = ~reset & out_valid & ~fifo_out_full;

  assign sum_next = 10'(fifo_in_dout[23:16]) + 10'(fifo_in_dout[15:8]) + 10'(fifo_in_dout[7:0]);

  // floor(s/3) == (s*683)>>11 for every s in 0..765, so no divider is needed.
  assign prod = 20'(sum_r) * 20'd683;
  assign div3 = DWIDTH_OUT'(prod >> 11);

  // Sum and divide stages; both hold together whenever adv is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignments so every stage
      // samples the pre-edge value of the stage before it.
      sum_r        <= '0;
      v1           <= 1'b0;
      fifo_out_din <= '0;
      out_valid    <= 1'b0;
    end else if (adv) begin
      sum_r        <= sum_next;
      v1           <= fifo_in_rd_en;
      fifo_out_din <= div3;
      out_valid    <= v1;
    end
  end

  // Raster position of the next pushed pixel, plus the end-of-frame pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (fifo_out_wr_en) begin
        if (x == X_LAST) begin
          x <= '0;
          if (y == Y_LAST) begin
            y          <= '0;
            frame_done <= 1'b1;
          end else begin
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb2gray.sv
// tb_rgb2gray: randomized self-checking bench for rgb2gray with a small
// 4x3 frame. FIFOs are modelled as queues, and the expected gray value is
// computed directly as (R+G+B)/3.
module tb_rgb2gray;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_in_rd_en;
  logic [23:0] fifo_in_dout = '0;
  logic        fifo_in_empty = 1'b1;
  logic        fifo_out_wr_en;
  logic [7:0]  fifo_out_din;
  logic        fifo_out_full = 1'b0;
  logic        frame_done;

  rgb2gray #(.DWIDTH_IN(24), .DWIDTH_OUT(8), .IMG_WIDTH(4), .IMG_HEIGHT(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_in_rd_en  (fifo_in_rd_en),
    .fifo_in_dout   (fifo_in_dout),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_out_wr_en (fifo_out_wr_en),
    .fifo_out_din   (fifo_out_din),
    .fifo_out_full  (fifo_out_full),
    .frame_done     (frame_done)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  int unsigned in_q[$], exp_q[$], got_q[$], saved_q[$];
  int          pop_c[$], wr_c[$], fd_c[$], fdxy[$];
  int          cyc = 0;
  int          viol = 0;
  int          p_full = 0, p_empty = 0, st_lo = 0, st_hi = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned req);
    checks++;
    if (obs !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, req);
    end
  endtask

  function automatic int unsigned gray(input int unsigned p);
    return (((p >> 16) & 255) + ((p >> 8) & 255) + (p & 255)) / 3;
  endfunction

  // One clock: drive inputs after the falling edge, then record the
  // handshakes that the next rising edge will act on.
  task automatic step(input bit rst);
    bit f, e;
    @(negedge clock);
    cyc++;
    f = (cyc >= st_lo && cyc < st_hi) || ($urandom_range(99) < p_full);
    e = (in_q.size() == 0) || ($urandom_range(99) < p_empty);
    reset         = rst;
    fifo_out_full = f;
    fifo_in_empty = e;
    fifo_in_dout  = (in_q.size() != 0) ? 24'(in_q[0]) : 24'h0;
    #1;
    if (fifo_in_rd_en) begin
      if (e || rst) viol++;
      else begin
        void'(in_q.pop_front());
        pop_c.push_back(cyc);
      end
    end
    if (fifo_out_wr_en) begin
      if (f || rst) viol++;
      got_q.push_back(fifo_out_din);
      wr_c.push_back(cyc);
    end
    if (frame_done) begin
      fd_c.push_back(cyc);
      fdxy.push_back(int'(dut.x) | int'(dut.y));
    end
  endtask

  task automatic reset_dut();
    in_q.delete(); exp_q.delete(); got_q.delete();
    pop_c.delete(); wr_c.delete(); fd_c.delete(); fdxy.delete();
    p_full = 0; p_empty = 0; st_lo = 0; st_hi = 0;
    step(1);
    cyc = 0;
  endtask

  task automatic push_pix(input int unsigned p);
    in_q.push_back(p);
    exp_q.push_back(gray(p));
  endtask

  task automatic run(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      step(0);
      k++;
    end
    if (got_q.size() < n) check("timeout", got_q.size(), n);
    for (int i = 0; i < 3; i++) step(0);
  endtask

  task automatic cmp_out(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic single(input string tag, input int unsigned p, input int unsigned req);
    reset_dut();
    push_pix(p);
    run(1, 20);
    check({tag, "_val"}, got_q[0], req);
    check({tag, "_lat"}, wr_c[0] - pop_c[0], 2);
  endtask

  initial begin
    int stall_wr, stall_pops, k;

    // Reset state: a waiting pixel must not be popped while reset is high.
    in_q.push_back(24'h123456);
    step(1);
    check("rst_rd_en", fifo_in_rd_en, 0);
    check("rst_wr_en", fifo_out_wr_en, 0);
    step(1);
    check("rst_din", fifo_out_din, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_wr_en2", fifo_out_wr_en, 0);
    check("rst_x_y", int'(dut.x) | int'(dut.y), 0);

    // Directed single pixels.
    single("white", 24'hFFFFFF, 8'hFF);
    single("p010001", 24'h010001, 8'h00);
    single("p102030", 24'h102030, 8'h20);

    // Every sum 0..765, streamed back to back.
    reset_dut();
    for (int s = 0; s <= 765; s++) begin
      int r, g;
      r = (s > 255) ? 255 : s;
      g = (s - r > 255) ? 255 : s - r;
      push_pix((r << 16) | (g << 8) | (s - r - g));
    end
    run(766, 2000);
    cmp_out("sum");
    check("sum764", got_q[764], 8'hFE);
    check("sum_frames", fd_c.size(), 766 / 12);

    // Unstalled streaming of 16 random pixels.
    reset_dut();
    for (int i = 0; i < 16; i++) push_pix($urandom & 24'hFFFFFF);
    saved_q = in_q;
    run(16, 100);
    check("str_pops", pop_c.size(), 16);
    check("str_pop_span", pop_c[15] - pop_c[0], 15);
    check("str_wr_span", wr_c[15] - wr_c[0], 15);
    check("str_first_lat", wr_c[0] - pop_c[0], 2);
    cmp_out("str");

    // Same pixels with full held high for 10 cycles mid-stream.
    reset_dut();
    foreach (saved_q[i]) push_pix(saved_q[i]);
    st_lo = 6; st_hi = 16;
    run(16, 100);
    stall_wr = 0; stall_pops = 0;
    foreach (wr_c[i])  if (wr_c[i]  >= st_lo && wr_c[i]  < st_hi) stall_wr++;
    foreach (pop_c[i]) if (pop_c[i] >= st_lo && pop_c[i] < st_hi) stall_pops++;
    check("bp_stall_writes", stall_wr, 0);
    check("bp_pops_over_2", stall_pops > 2, 0);
    cmp_out("bp");

    // Random empty/full toggling over 1000 pixels.
    reset_dut();
    p_full = 30; p_empty = 30;
    for (int i = 0; i < 1000; i++) push_pix($urandom & 24'hFFFFFF);
    run(1000, 8000);
    cmp_out("rnd");

    // Two 4x3 frames back to back under light backpressure.
    reset_dut();
    p_full = 20;
    for (int i = 0; i < 24; i++) push_pix($urandom & 24'hFFFFFF);
    run(24, 400);
    check("fr_pulses", fd_c.size(), 2);
    check("fr_pulse0", fd_c[0], wr_c[11] + 1);
    check("fr_pulse1", fd_c[1], wr_c[23] + 1);
    check("fr_xy0", fdxy[0], 0);
    check("fr_xy1", fdxy[1], 0);
    cmp_out("fr");

    // Reset after 5 writes with 2 pixels in flight; they must be lost.
    reset_dut();
    for (int i = 0; i < 7; i++) push_pix($urandom & 24'hFFFFFF);
    k = 0;
    while (got_q.size() < 5 && k < 50) begin
      step(0);
      k++;
    end
    check("mid_pre_writes", got_q.size(), 5);
    check("mid_all_popped", in_q.size(), 0);
    step(1);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    for (int i = 0; i < 4; i++) step(0);
    check("mid_no_flush", got_q.size(), 5);
    fd_c.delete();
    for (int i = 0; i < 12; i++) push_pix($urandom & 24'hFFFFFF);
    run(17, 100);
    cmp_out("mid");
    check("mid_pulses", fd_c.size(), 1);
    check("mid_pulse", fd_c[0], wr_c[16] + 1);

    check("handshake_violations", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
